// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types and constants for the AD block padder
package ascon_pkg;
    localparam int RATE_BYTES = 8;
    localparam int RATE_BITS = 8 * RATE_BYTES;
    localparam int DATALEN_W = 4;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    typedef enum logic [1:0] {IDLE, FILL, HOLD} padder_state_t;
endpackage

// File: rtl/byte_lane_writer.sv
// byte_lane_writer: returns blk_in with big-endian lane idx replaced by b when we is high
module byte_lane_writer
    import ascon_pkg::*;
(
    input  logic [RATE_BITS-1:0] blk_in,
    input  logic [2:0]           idx,
    input  logic [7:0]           b,
    input  logic                 we,
    output logic [RATE_BITS-1:0] blk_out
);
    always_comb begin
        blk_out = blk_in;
        for (int i = 0; i < RATE_BYTES; i++)
            if (we && idx == 3'(i)) blk_out[8*(RATE_BYTES-1-i) +: 8] = b;
    end
endmodule

// File: rtl/ad_block_padder.sv
// ad_block_padder: collects up to 8 AD bytes into a big-endian rate block, 10* pads it,
// and holds it for the permutation core under a valid/ready handshake.
module ad_block_padder
    import ascon_pkg::*;
(
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 busy,
    input  logic                 start,
    input  logic [DATALEN_W-1:0] datalen,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [RATE_BITS-1:0] block_out,
    output logic                 block_valid,
    input  logic                 block_ready,
    output logic                 padded
);
    padder_state_t state;
    logic [3:0] len, count, count_nxt, len_clamped;
    logic accept, done, pad_en;
    logic [RATE_BITS-1:0] blk_data, blk_pad;

    assign len_clamped = (datalen > 4'd8) ? 4'd8 : datalen;
    assign accept = (state == FILL) && byte_valid && (count < len);
    assign count_nxt = accept ? count + 4'd1 : count;
    assign done = (state == FILL) && busy && (count_nxt == len);
    assign pad_en = done && (len < 4'd8);

    byte_lane_writer u_data (
        .blk_in(block_out), .idx(count[2:0]), .b(byte_in), .we(accept), .blk_out(blk_data)
    );
    // Pad lane is written in the same edge that completes the block
    byte_lane_writer u_pad (
        .blk_in(blk_data), .idx(len[2:0]), .b(PAD_BYTE), .we(pad_en), .blk_out(blk_pad)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            block_out <= '0;
            block_valid <= 1'b0;
            byte_ready <= 1'b0;
            padded <= 1'b0;
            count <= '0;
            len <= '0;
        end else begin
            case (state)
                IDLE: if (start && busy) begin
                    state <= FILL;
                    len <= len_clamped;
                    count <= '0;
                    block_out <= '0;
                    byte_ready <= (len_clamped != 4'd0);
                end
                FILL: if (!busy) begin
                    state <= IDLE;
                    byte_ready <= 1'b0;
                end else begin
                    block_out <= blk_pad;
                    count <= count_nxt;
                    if (done) begin
                        state <= HOLD;
                        byte_ready <= 1'b0;
                        block_valid <= 1'b1;
                        padded <= (len < 4'd8);
                    end
                end
                HOLD: if (block_ready || !busy) begin
                    state <= IDLE;
                    block_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ad_block_padder.md
Name: ad_block_padder

Overview:
- Downstream companion of the AD loader.
- Takes the loader's per-block byte count (`datalen`, 0..8) and a byte stream from the I/O side.
- Assembles one 64-bit rate block, big-endian: first byte in [63:56].
- Applies ASCON 10* padding (0x80, then zeros) when fewer than 8 bytes are supplied.
- Presents the block to the permutation core with a valid/ready handshake. The core's accept strobe is the same signal the loader sees as `AD_read`.

Parameters:
- RATE_BYTES, 8, bytes per rate block (block width = 8*RATE_BYTES).
- PAD_BYTE, 8'h80, padding byte inserted at index `len` when `len` < RATE_BYTES.

Ports:
- clk  input  1  system clock
- RST  input  1  synchronous, active-high reset
- busy  input  1  engine busy; low aborts any block in progress
- start  input  1  one-cycle pulse: begin a block of `datalen` bytes
- datalen  input  4  bytes to collect (0..8; values >8 are clamped to 8)
- byte_in  input  8  incoming data byte
- byte_valid  input  1  `byte_in` is valid
- byte_ready  output  1  block accepts a byte this cycle
- block_out  output  64  assembled and padded block
- block_valid  output  1  `block_out` is valid
- block_ready  input  1  core accepts the block (AD_read)
- padded  output  1  block contains a pad byte (`len` < 8); qualified by `block_valid`

Behaviour:
- Reset (RST high at a clk edge): state=IDLE; `block_out`=0; `block_valid`=0; `byte_ready`=0; `padded`=0; count=0; len=0. Applies from any state, including mid-fill and mid-hold.
- Clock and reset: one clock, `clk`; reset `RST` is synchronous and active-high.
- State machine IDLE / FILL / HOLD:
  - IDLE:
    - `byte_ready`=0, `block_valid`=0.
    - On `start` & `busy`: len = min(`datalen`, 8); count=0; block register cleared to 0; next=FILL.
    - `start` with `busy` low is ignored.
  - FILL:
    - `byte_ready` = (count < len).
    - A byte is accepted when `byte_valid` & `byte_ready`; it is written to byte lane `count` (bits [63-8*count -: 8]) and count increments.
    - When count == len is reached (next-count for the accepting cycle, or immediately when len=0), next=HOLD. In the same edge, lane `len` is written with PAD_BYTE if len < 8.
    - len=0: FILL lasts exactly one cycle with `byte_ready`=0; the block becomes 0x8000_0000_0000_0000.
  - HOLD:
    - `block_valid`=1; `block_out` and `padded` are stable.
    - On `block_ready`: next=IDLE, and `block_valid` drops the following cycle.
    - `block_ready` is ignored outside HOLD.
- Latency:
  - Last byte accepted at edge N → `block_valid`=1 after edge N.
  - len=0: `start` at edge N → `block_valid` after edge N+1.
- Back-to-back operation: `start` is only honoured in IDLE. A `start` in FILL or HOLD is ignored, with no error flag; the loader guarantees spacing.
- Abort: `busy` low in FILL or HOLD → next=IDLE; partial data is discarded and `block_valid` deasserts. `busy` low and `block_ready` in the same cycle of HOLD counts as an accept, then IDLE.
- Bytes offered in IDLE or HOLD are not consumed (`byte_ready`=0).
- Unused lanes beyond the pad byte are always 0.
- Width rules:
  - count is 4 bits and ranges 0..8.
  - Clamp compares `datalen` > 8 as an unsigned 4-bit value.
  - The lane index never exceeds 7 on a data write.

Decomposition:
- Shared package `ascon_pkg`:
  - `padder_state_t` enum {IDLE, FILL, HOLD}
  - RATE_BYTES / RATE_BITS constants
  - PAD_BYTE constant
  - `datalen` width constant
- One sub-module is natural: `byte_lane_writer`. It is combinational: given a 64-bit block, a lane index, a byte and a write enable, it returns the updated block. It is used once for data writes and once for the pad insert.

Test Plan:
- Full block: `start` with `datalen`=8, bytes 01..08 with `byte_valid` held high → `block_out`=0x0102030405060708, `padded`=0, `block_valid` one cycle after the 8th byte.
- Partial block: `datalen`=3, bytes AA, BB, CC → `block_out`=0xAABBCC8000000000, `padded`=1; `byte_ready` falls after the 3rd byte.
- Empty block and back-pressure: `datalen`=0 → `block_out`=0x8000000000000000 valid 2 cycles after `start`. Hold `block_ready` low 5 cycles → output stable; one cycle of `block_ready` → IDLE.
- Clamp and gaps: `datalen`=12, bytes 11..88 with `byte_valid` toggling every other cycle → block 0x1122334455667788, exactly 8 bytes consumed, a 9th byte is not accepted.
- Abort: `datalen`=6, 2 bytes sent, then `busy` low → IDLE, `block_valid` never asserts. A following `start` with `datalen`=1, byte 5A → 0x5A80000000000000 (no stale data).
- Reset mid-operation: RST asserted in HOLD with `block_valid`=1 → after the edge, `block_valid`=0, `block_out`=0, state=IDLE. A `start` on the same edge as RST is ignored.
